pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline hazard controller for the 5-stage core.
- Generates the hold and scour (flush) flags for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates the fetch redirect.
- Sequences three hazard classes: load-use bubbles, branch-prediction correction from EX, and multi-cycle stalls (data-memory wait with timeout, iterative divider).

Parameters:
- ADDR_W, 32, width of PC and redirect address.
- DIV_LAT, 33, maximum divider latency in cycles; bounds the DIV_BUSY stall.
- MEM_TIMEOUT, 64, cycles allowed for a data-memory acknowledge before an error.
- TRAP_ADDR, 32'h0000_0010, redirect target on memory timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_jump_i  in  1  branch/jump in EX resolved taken
- ex_jump_bp_i  in  1  prediction flag carried with the EX instruction
- ex_jump_addr_i  in  ADDR_W  resolved target from EX
- ex_pc_i  in  ADDR_W  PC of the EX instruction
- load_use_i  in  1  ID instruction sources the rd of a load currently in EX
- div_start_i  in  1  divide instruction issuing in EX (1-cycle pulse)
- div_done_i  in  1  divider result valid
- mem_req_i  in  1  MEM stage has an outstanding data access
- mem_ack_i  in  1  data access completed this cycle
- pc_hold_o  out  1  freeze PC
- if_id_hold_o  out  1  freeze IF/ID
- if_id_scour_o  out  1  flush IF/ID
- id_ex_hold_o  out  1  freeze ID/EX
- id_ex_scour_o  out  1  flush ID/EX (insert bubble)
- ex_mem_hold_o  out  1  freeze EX/MEM
- ex_mem_scour_o  out  1  flush EX/MEM
- redirect_o  out  1  load PC with redirect_addr_o
- redirect_addr_o  out  ADDR_W  new fetch address
- mem_err_o  out  1  1-cycle pulse on memory timeout

Behaviour:
- Registered state: FSM {IDLE, MEM_WAIT, DIV_BUSY} and 7-bit counter cnt (wide enough for both DIV_LAT and MEM_TIMEOUT). All outputs are combinational from state, cnt and inputs.
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0. All outputs 0 and redirect_addr_o=0, for as long as rst_n is low and independent of the inputs.
- mispredict = ex_jump_i ^ ex_jump_bp_i.
- Correct target: ex_jump_addr_i when ex_jump_i=1, else ex_pc_i+4, modulo 2^ADDR_W.

IDLE, priority high to low:
1. mem_req_i && !mem_ack_i:
   - Hold pc, if_id, id_ex, ex_mem this cycle.
   - Next state MEM_WAIT, cnt<=1.
   - Any concurrent mispredict is deferred, because EX is frozen and is re-evaluated on release.
2. div_start_i:
   - Hold pc, if_id, id_ex, ex_mem.
   - Next state DIV_BUSY, cnt<=DIV_LAT-1.
3. mispredict:
   - redirect_o=1 with the correct target.
   - if_id_scour_o=1, id_ex_scour_o=1. No holds.
4. load_use_i:
   - pc_hold_o=1, if_id_hold_o=1, id_ex_scour_o=1 for exactly this cycle.
5. Otherwise: all outputs 0.

MEM_WAIT:
- mem_ack_i=1: next state IDLE. This cycle, IDLE rules 2-5 apply, which releases the stall with zero added latency.
- mem_ack_i=0 and cnt==MEM_TIMEOUT-1:
  - mem_err_o=1, redirect_o=1, redirect_addr_o=TRAP_ADDR.
  - if_id_scour_o, id_ex_scour_o and ex_mem_scour_o all 1.
  - Next state IDLE, cnt<=0.
- Otherwise: all four holds asserted, cnt<=cnt+1.

DIV_BUSY:
- div_done_i=1 or cnt==0: next state IDLE; this cycle all holds 0 and IDLE rules 3-5 apply.
- Otherwise: all four holds asserted, cnt<=cnt-1.
- div_done_i with cnt==0 in the same cycle: single release, no double event.

Invariants:
- Scour and hold are never asserted together for the same register.
- Scour wins in the downstream register convention.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o [31:0] and perf_flush_cnt_o [31:0]. Both saturate at 32'hFFFF_FFFF and reset to 0.
  - perf_stall_cnt_o increments each cycle pc_hold_o=1.
  - perf_flush_cnt_o increments each cycle redirect_o=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 with all inputs 1 -> every output 0. Release rst_n -> state IDLE, outputs follow IDLE rules next cycle.
2. Mispredict: ex_jump_i=1, ex_jump_bp_i=0, ex_jump_addr_i=0x200 -> same cycle redirect_o=1, addr 0x200, if_id/id_ex scour=1.
   Then ex_jump_i=0, ex_jump_bp_i=1, ex_pc_i=0x100 -> redirect addr 0x104.
3. Load-use: load_use_i=1 for one cycle -> pc_hold/if_id_hold/id_ex_scour=1 for exactly that cycle, 0 the next.
4. Memory wait: mem_req_i=1, ack after 5 cycles -> holds asserted 5 cycles and drop in the ack cycle.
   Concurrent mispredict during the wait is redirected only in the ack cycle.
5. Memory timeout: mem_req_i=1, ack never arrives -> after MEM_TIMEOUT=64 cycles: mem_err_o pulse, redirect to 0x10, three scours, return to IDLE.
6. Divider: div_start_i pulse, div_done_i at cycle 10 -> holds for 10 cycles, released in the done cycle.
   Without div_done_i -> release after DIV_LAT=33 cycles. With PIPE_CTRL_PERF_EN, perf_stall_cnt_o equals total hold cycles.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage core: hold/scour flags, fetch redirect, stall sequencing.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                DIV_LAT     = 33,
    parameter int                MEM_TIMEOUT = 64,
    parameter logic [ADDR_W-1:0] TRAP_ADDR   = ADDR_W'(32'h0000_0010)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_jump_i,
    input  logic              ex_jump_bp_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              load_use_i,
    input  logic              div_start_i,
    input  logic              div_done_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_hold_o,
    output logic              if_id_hold_o,
    output logic              if_id_scour_o,
    output logic              id_ex_hold_o,
    output logic              id_ex_scour_o,
    output logic              ex_mem_hold_o,
    output logic              ex_mem_scour_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic              mem_err_o,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
`else
    output logic              mem_err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [6:0]  cnt_r;
    logic [6:0]  cnt_s;
    logic        free_s;
    logic        div_ok_s;
    logic        hold_all_s;
    logic        lu_s;
    logic        flush_s;
    logic        trap_s;
    logic        mispredict_s;

    function automatic logic [ADDR_W-1:0] correct_target(
        input logic              jump,
        input logic [ADDR_W-1:0] jaddr,
        input logic [ADDR_W-1:0] pc
    );
        return jump ? jaddr : (pc + ADDR_W'(32'd4));
    endfunction

    assign mispredict_s = ex_jump_i ^ ex_jump_bp_i;

    // Hazard arbitration: stall state first, then divider start, mispredict, load-use.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        free_s     = 1'b0;
        div_ok_s   = 1'b0;
        hold_all_s = 1'b0;
        lu_s       = 1'b0;
        flush_s    = 1'b0;
        trap_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_req_i && !mem_ack_i) begin
                    hold_all_s = 1'b1;
                    state_s    = MEM_WAIT;
                    cnt_s      = 7'd1;
                end else begin
                    free_s   = 1'b1;
                    div_ok_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_s  = IDLE;
                    cnt_s    = 7'd0;
                    free_s   = 1'b1;
                    div_ok_s = 1'b1;
                end else if (cnt_r == 7'(MEM_TIMEOUT - 1)) begin
                    trap_s  = 1'b1;
                    state_s = IDLE;
                    cnt_s   = 7'd0;
                end else begin
                    hold_all_s = 1'b1;
                    cnt_s      = cnt_r + 7'd1;
                end
            end
            DIV_BUSY: begin
                // done and an expired count together still give one release
                if (div_done_i || (cnt_r == 7'd0)) begin
                    state_s = IDLE;
                    cnt_s   = 7'd0;
                    free_s  = 1'b1;
                end else begin
                    hold_all_s = 1'b1;
                    cnt_s      = cnt_r - 7'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 7'd0;
            end
        endcase

        if (free_s && div_ok_s && div_start_i) begin
            hold_all_s = 1'b1;
            state_s    = DIV_BUSY;
            cnt_s      = 7'(DIV_LAT - 1);
        end else if (free_s && mispredict_s) begin
            flush_s = 1'b1;
        end else if (free_s && load_use_i) begin
            lu_s = 1'b1;
        end else begin
            lu_s = 1'b0;
        end
    end

    // Output decode; everything forced low while reset is asserted.
    assign pc_hold_o       = rst_n & (hold_all_s | lu_s);
    assign if_id_hold_o    = rst_n & (hold_all_s | lu_s);
    assign id_ex_hold_o    = rst_n & hold_all_s;
    assign ex_mem_hold_o   = rst_n & hold_all_s;
    assign if_id_scour_o   = rst_n & (flush_s | trap_s);
    assign id_ex_scour_o   = rst_n & (flush_s | trap_s | lu_s);
    assign ex_mem_scour_o  = rst_n & trap_s;
    assign redirect_o      = rst_n & (flush_s | trap_s);
    assign mem_err_o       = rst_n & trap_s;
    assign redirect_addr_o = !rst_n ? '0 :
                             trap_s ? TRAP_ADDR :
                             flush_s ? correct_target(ex_jump_i, ex_jump_addr_i, ex_pc_i) : '0;

    // Controller state and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 7'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating performance counters for stalled and redirected cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (pc_hold_o && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_o && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_r;
    assign perf_flush_cnt_o = flush_cnt_r;
`endif

endmodule
